// File: rtl/fsm_seq_arb_pkg.sv
// Shared state encodings and parameter defaults for the sequencer arbiter.
package fsm_seq_arb_pkg;

  localparam int unsigned NREQ_DEF   = 4;
  localparam int unsigned HOLD_W_DEF = 4;
  localparam int unsigned TMO_DEF    = 15;

  typedef enum logic [7:0] {
    S_IDLE   = 8'b0000_0001,
    S_GRANT  = 8'b0000_0010,
    S_HI1    = 8'b0000_0100,
    S_LO1    = 8'b0000_1000,
    S_HI2    = 8'b0001_0000,
    S_LO2    = 8'b0010_0000,
    S_FINISH = 8'b0100_0000,
    S_ERR    = 8'b1000_0000
  } state_t;

endpackage

// File: rtl/fsm_seq_arb_rr.sv
// Round-robin selector: first asserted request at or after ptr, one-hot.
module rr_arbiter
  import fsm_seq_arb_pkg::*;
#(
  parameter  int unsigned NREQ = NREQ_DEF,
  localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt_next
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    gnt_next = '0;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = PW'((32'(ptr) + i) % NREQ);
      if (en && !found && req[idx]) begin
        gnt_next[idx] = 1'b1;
        found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fsm_seq_arb.sv
// Arbitrates NREQ requesters onto one downstream A/K1/K2 sequencer and
// drives the A handshake (timed HI1/LO1, K-acknowledged HI2/LO2 with timeout).
module fsm_seq_arb
  import fsm_seq_arb_pkg::*;
#(
  parameter int unsigned NREQ   = NREQ_DEF,
  parameter int unsigned HOLD_W = HOLD_W_DEF,
  parameter int unsigned TMO    = TMO_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [NREQ-1:0]   req,
  input  logic [HOLD_W-1:0] hold,
  input  logic              K1,
  input  logic              K2,
  output logic              A,
  output logic              fsm_rstn,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned TW = $clog2(TMO + 1);
  localparam int unsigned CW = (HOLD_W > TW) ? HOLD_W : TW;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [HOLD_W-1:0] h_q, h_d;
  logic [PW-1:0]     win_q, win_d, ptr_q, ptr_d, win_sel;
  logic [NREQ-1:0]   gnt_next, gnt_d;
  logic              a_d, busy_d, done_d, err_d, rstn_d;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req      (req),
    .ptr      (ptr_q),
    .en       (state_q == S_IDLE),
    .gnt_next (gnt_next)
  );

  always_comb begin
    win_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_next[i]) win_sel = PW'(i);
    end
  end

  // cnt_d defaults to zero so every state change restarts the phase counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    h_d     = h_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (|gnt_next) begin
          state_d = S_GRANT;
          win_d   = win_sel;
        end
      end
      S_GRANT: begin
        h_d     = (hold == '0) ? HOLD_W'(1) : hold;
        state_d = S_HI1;
      end
      S_HI1: begin
        if (cnt_q == CW'(h_q) - CW'(1)) state_d = S_LO1;
        else                            cnt_d   = cnt_q + CW'(1);
      end
      S_LO1: begin
        if (cnt_q == CW'(h_q) - CW'(1)) state_d = S_HI2;
        else                            cnt_d   = cnt_q + CW'(1);
      end
      S_HI2: begin
        if (K2)                           state_d = S_LO2;
        else if (cnt_q == CW'(TMO - 1))   state_d = S_ERR;
        else                              cnt_d   = cnt_q + CW'(1);
      end
      S_LO2: begin
        if (K1)                           state_d = S_FINISH;
        else if (cnt_q == CW'(TMO - 1))   state_d = S_ERR;
        else                              cnt_d   = cnt_q + CW'(1);
      end
      S_FINISH, S_ERR: begin
        state_d = S_IDLE;
        ptr_d   = (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    a_d    = (state_d == S_HI1) || (state_d == S_HI2);
    busy_d = state_d inside {S_GRANT, S_HI1, S_LO1, S_HI2, S_LO2, S_FINISH};
    gnt_d  = busy_d ? (NREQ'(1) << win_d) : '0;
    done_d = (state_d == S_FINISH);
    err_d  = (state_d == S_ERR);
    rstn_d = !err_d;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      h_q      <= '0;
      win_q    <= '0;
      ptr_q    <= '0;
      A        <= 1'b0;
      gnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      fsm_rstn <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      h_q      <= h_d;
      win_q    <= win_d;
      ptr_q    <= ptr_d;
      A        <= a_d;
      gnt      <= gnt_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
      fsm_rstn <= rstn_d;
    end
  end

endmodule

// File: tb/tb_fsm_seq_arb.sv
// Directed self-checking bench for fsm_seq_arb with hand-computed traces.
module tb_fsm_seq_arb;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned HOLD_W = 4;
  localparam int unsigned TMO    = 15;

  logic              Clock = 1'b0;
  logic              Reset = 1'b0;
  logic [NREQ-1:0]   req   = '0;
  logic [HOLD_W-1:0] hold  = '0;
  logic              K1    = 1'b0;
  logic              K2    = 1'b0;
  logic              A, fsm_rstn, busy, done, err;
  logic [NREQ-1:0]   gnt;

  int checks   = 0;
  int failures = 0;

  always #5 Clock = ~Clock;

  fsm_seq_arb #(.NREQ(NREQ), .HOLD_W(HOLD_W), .TMO(TMO)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .req      (req),
    .hold     (hold),
    .K1       (K1),
    .K2       (K2),
    .A        (A),
    .fsm_rstn (fsm_rstn),
    .gnt      (gnt),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic ea, input logic [3:0] eg,
                            input logic eb, input logic ed, input logic ee, input logic er);
    check_eq({tag, ".A"},        32'(A),        32'(ea));
    check_eq({tag, ".gnt"},      32'(gnt),      32'(eg));
    check_eq({tag, ".busy"},     32'(busy),     32'(eb));
    check_eq({tag, ".done"},     32'(done),     32'(ed));
    check_eq({tag, ".err"},      32'(err),      32'(ee));
    check_eq({tag, ".fsm_rstn"}, 32'(fsm_rstn), 32'(er));
  endtask

  task automatic step(input string tag, input logic ea, input logic [3:0] eg,
                      input logic eb, input logic ed, input logic ee, input logic er);
    @(posedge Clock);
    #1;
    check_outs(tag, ea, eg, eb, ed, ee, er);
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    req   = '0;
    K1    = 1'b0;
    K2    = 1'b0;
    #7;
    check_outs("rst", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge Clock);
    Reset = 1'b1;
    step("post_rst", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Full sequence: K2 arrives after w2 extra HI2 cycles, K1 after w1 extra LO2 cycles.
  task automatic run_seq(input logic [3:0] rq, input logic [3:0] hv, input logic [3:0] eg,
                         input int w2, input int w1, input logic keep);
    int h;
    h    = (hv == 4'd0) ? 1 : int'(hv);
    hold = hv;
    req  = rq;
    step("grant", 1'b0, eg, 1'b1, 1'b0, 1'b0, 1'b1);
    if (!keep) req = '0;
    for (int i = 0; i < h; i++) begin
      K1 = (i == 0);
      K2 = (i == 0);
      step("hi1", 1'b1, eg, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    K1 = 1'b0;
    K2 = 1'b0;
    for (int i = 0; i < h; i++) step("lo1", 1'b0, eg, 1'b1, 1'b0, 1'b0, 1'b1);
    step("hi2", 1'b1, eg, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < w2; i++) begin
      K1 = 1'b1;
      step("hi2_wait", 1'b1, eg, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    K1 = 1'b0;
    K2 = 1'b1;
    step("lo2", 1'b0, eg, 1'b1, 1'b0, 1'b0, 1'b1);
    K2 = 1'b0;
    for (int i = 0; i < w1; i++) step("lo2_wait", 1'b0, eg, 1'b1, 1'b0, 1'b0, 1'b1);
    K1 = 1'b1;
    step("finish", 1'b0, eg, 1'b1, 1'b1, 1'b0, 1'b1);
    K1 = 1'b0;
    step("idle", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Timeout in HI2 (in_lo2=0) or LO2 (in_lo2=1); the awaited K never comes.
  task automatic run_tmo(input logic [3:0] rq, input logic [3:0] eg, input logic in_lo2);
    hold = 4'd1;
    req  = rq;
    step("t_grant", 1'b0, eg, 1'b1, 1'b0, 1'b0, 1'b1);
    req = '0;
    step("t_hi1", 1'b1, eg, 1'b1, 1'b0, 1'b0, 1'b1);
    step("t_lo1", 1'b0, eg, 1'b1, 1'b0, 1'b0, 1'b1);
    step("t_hi2", 1'b1, eg, 1'b1, 1'b0, 1'b0, 1'b1);
    if (in_lo2) begin
      K2 = 1'b1;
      step("t_lo2", 1'b0, eg, 1'b1, 1'b0, 1'b0, 1'b1);
      K2 = 1'b0;
    end
    for (int i = 0; i < int'(TMO) - 1; i++)
      step("tmo_wait", !in_lo2, eg, 1'b1, 1'b0, 1'b0, 1'b1);
    step("err", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    step("post_err", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();

    // Single requester, hold=2, then hold=0 with ptr=1 picking bit1 of 0011.
    run_seq(4'b0001, 4'd2, 4'b0001, 0, 1, 1'b0);
    run_seq(4'b0011, 4'd0, 4'b0010, 2, 0, 1'b0);

    // Simultaneous 0110 from ptr=0, back-to-back, then ptr=3 shows via 1001.
    do_reset();
    run_seq(4'b0110, 4'd2, 4'b0010, 1, 0, 1'b1);
    run_seq(4'b0110, 4'd2, 4'b0100, 0, 0, 1'b0);
    run_seq(4'b1001, 4'd1, 4'b1000, 0, 0, 1'b0);

    // Timeouts; ptr advances past the failed winner each time.
    run_tmo(4'b0100, 4'b0100, 1'b0);
    run_tmo(4'b0011, 4'b0001, 1'b1);
    run_seq(4'b0101, 4'd1, 4'b0100, 0, 0, 1'b0);

    // Reset in LO1: immediate reset values, then a fresh grant from ptr=0.
    hold = 4'd3;
    req  = 4'b0001;
    step("r_grant", 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step("r_hi1", 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1);
    step("r_lo1", 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1);
    #2;
    Reset = 1'b0;
    #1;
    check_outs("midrst", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    step("midrst_hold", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge Clock);
    Reset = 1'b1;
    run_seq(4'b0001, 4'd3, 4'b0001, 0, 0, 1'b0);

    // All four requesting continuously: strict rotation 0,1,2,3,0,1,2,3.
    do_reset();
    for (int k = 0; k < 8; k++)
      run_seq(4'b1111, 4'd1, 4'(1 << (k % 4)), 0, 0, 1'b1);
    req = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
